alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Command sequencer for the 8-bit alu. Accepts accumulator commands over a valid/ready
//  handshake, drives alu a/b/s, and writes alu r/c/v back into an 8-bit accumulator with flags.
//  Adds a multi-cycle unsigned multiply (shift-add through the alu ADD op).
//  Sits between the front-panel/command source and the alu instance.
// PARAMETERS
//  MUL_EN  1  1: MUL command supported; 0: MUL (4'h7) treated as illegal
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  cmd_valid  in   1  command present
//  cmd_ready  out  1  controller can accept; high only in IDLE and while rst_n=1
//  cmd_op     in   4  command code (see BEHAVIOUR)
//  cmd_opnd   in   8  command operand
//  alu_a      out  8  to alu a
//  alu_b      out  8  to alu b
//  alu_s      out  4  to alu s; only codes 1110,1101,1100,1011,1010,1001,1000 ever driven
//  alu_r      in   8  from alu r
//  alu_c      in   1  from alu c
//  alu_v      in   1  from alu v
//  acc        out  8  accumulator
//  flag_c     out  1  unsigned carry of last completed op
//  flag_v     out  1  signed overflow of last completed op
//  flag_z     out  1  acc==0
//  busy       out  1  state != IDLE
//  done       out  1  one-cycle pulse: command completed
//  err        out  1  one-cycle pulse with done: illegal command
// BEHAVIOUR
//  Reset (async): state=IDLE, acc=0, flag_c=flag_v=0, flag_z=1, done=err=busy=0, alu_s=4'b1000, alu_a=alu_b=0.
//  Handshake: accept on rising edge where cmd_valid & cmd_ready; op/opnd latched. cmd_valid while busy: ignored.
//  Commands (alu_a=acc unless stated, alu_b=latched opnd):
//   0 LOAD  s=1000, a=opnd; acc<=opnd, c=v=0
//   1 AND s=1110 | 2 OR s=1101 | 3 XOR s=1011: acc<=r, c=v=0
//   4 ADD s=1010 | 5 SUB s=1001: acc<=r, c<=alu_c, v<=alu_v (SUB: c=1 means no borrow)
//   6 NOT s=1100; acc<=~acc, c=v=0
//   7 MUL acc<=low 8 bits of acc*opnd (unsigned); c=1 iff full product>255; v=0
//   8..F illegal: acc/flags unchanged, err=1
//  flag_z always equals (acc==0) after every acc write.
//  FSM: IDLE -> EXEC (ops 0-6, illegal) -> IDLE; IDLE -> MUL (8 cycles) -> IDLE.
//   EXEC: one cycle; alu driven combinationally from latched cmd; result registered at end of cycle.
//   MUL: internal p (8b, init 0), m (shifted multiplicand, init acc), q (multiplier, init opnd), cnt 0..7.
//    Each cycle: s=1010, a=p, b=m; if q[cnt] then p<=r and sticky carry |= alu_c; m<=m<<1,
//    sticky carry |= (q[cnt+1..7]!=0 & m[7]); after cnt=7 acc<=p, flag_c<=sticky.
//  Latency: handshake edge E0. Single ops: acc/flags updated at E1, done=1 in cycle after E1.
//   MUL: acc/flags updated at E8, done=1 in cycle after E8. cmd_ready high again in the done cycle,
//   so back-to-back commands lose no cycles.
//  done/err registered, exactly one cycle wide; never asserted without a completed command.
//  Arithmetic wraps modulo 256; no saturation.
//  MUL with opnd=0 or acc=0 still takes 8 cycles; result 0, c=0.
//  Reset mid-command: command abandoned, all outputs to reset values, no done pulse.
//  MUL_EN=0: op 7 follows illegal path (EXEC, err=1).
// TESTING
//  LOAD 0x7F, ADD 0x01 -> acc=0x80, c=0, v=1, z=0; done 1 cycle after update.
//  LOAD 0x05, SUB 0x05 -> acc=0x00, c=1, v=0, z=1; LOAD 0x03, SUB 0x05 -> acc=0xFE, c=0.
//  LOAD 0x0C, MUL 0x0B -> acc=0x84, c=0; done exactly 8 clocks after handshake edge + 1; busy high throughout.
//  LOAD 0x20, MUL 0x10 -> acc=0x00, c=1, z=1; cmd_valid pulsed mid-MUL -> not accepted, acc unaffected.
//  cmd_op=4'hF with acc=0x5A -> err=1 with done, acc=0x5A, flags unchanged; MUL_EN=0 op 7 -> err=1.
//  rst_n low at MUL cycle 4 -> immediate acc=0, z=1, busy=0, no done; next LOAD 0x11 works normally.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the 8-bit alu: accepts accumulator commands over valid/ready,
// drives alu a/b/s and writes r/c/v back into an accumulator, with a shift-add multiply.
module alu_seq_ctrl #(
  parameter int MUL_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_opnd,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_s,
  input  logic [7:0] alu_r,
  input  logic       alu_c,
  input  logic       alu_v,
  output logic [7:0] acc,
  output logic       flag_c,
  output logic       flag_v,
  output logic       flag_z,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;

  localparam logic [3:0] OP_LOAD = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_MUL  = 4'h7;

  localparam logic [3:0] S_PASS = 4'b1000;
  localparam logic [3:0] S_AND  = 4'b1110;
  localparam logic [3:0] S_OR   = 4'b1101;
  localparam logic [3:0] S_XOR  = 4'b1011;
  localparam logic [3:0] S_ADD  = 4'b1010;
  localparam logic [3:0] S_SUB  = 4'b1001;
  localparam logic [3:0] S_NOT  = 4'b1100;

  localparam bit MUL_ON = (MUL_EN != 0);

  logic [1:0] state;
  logic [3:0] op_q;
  logic [7:0] opnd_q;
  logic [7:0] acc_q;
  logic       c_q;
  logic       v_q;
  logic       done_q;
  logic       err_q;

  // multiply datapath: partial product, shifted multiplicand, multiplier, step
  logic [7:0] p;
  logic [7:0] m;
  logic [7:0] q;
  logic [2:0] cnt;
  logic       sticky;

  logic       accept;
  logic [7:0] hi_mask;
  logic [7:0] p_nx;
  logic       sticky_nx;

  assign cmd_ready = (state == IDLE) && rst_n;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);
  assign acc       = acc_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign flag_z    = (acc_q == '0);
  assign done      = done_q;
  assign err       = err_q;

  // Product overflows if a set multiplicand bit is about to shift out while
  // higher multiplier bits are still pending, or if any partial add carries.
  always_comb begin
    hi_mask   = 8'hFE << cnt;
    p_nx      = q[cnt] ? alu_r : p;
    sticky_nx = sticky | (q[cnt] & alu_c) | (((q & hi_mask) != '0) & m[7]);
  end

  always_comb begin
    alu_s = S_PASS;
    alu_a = '0;
    alu_b = '0;
    case (state)
      EXEC: begin
        alu_a = acc_q;
        alu_b = opnd_q;
        case (op_q)
          OP_LOAD: begin
            alu_s = S_PASS;
            alu_a = opnd_q;
          end
          OP_AND:  alu_s = S_AND;
          OP_OR:   alu_s = S_OR;
          OP_XOR:  alu_s = S_XOR;
          OP_ADD:  alu_s = S_ADD;
          OP_SUB:  alu_s = S_SUB;
          OP_NOT:  alu_s = S_NOT;
          default: alu_s = S_PASS;
        endcase
      end
      MUL: begin
        alu_s = S_ADD;
        alu_a = p;
        alu_b = m;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      p      <= '0;
      m      <= '0;
      q      <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= cmd_op;
            opnd_q <= cmd_opnd;
            if (MUL_ON && cmd_op == OP_MUL) begin
              state  <= MUL;
              p      <= '0;
              m      <= acc_q;
              q      <= cmd_opnd;
              cnt    <= '0;
              sticky <= 1'b0;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          state  <= IDLE;
          done_q <= 1'b1;
          case (op_q)
            OP_LOAD: begin
              acc_q <= opnd_q;
              c_q   <= 1'b0;
              v_q   <= 1'b0;
            end
            OP_AND, OP_OR, OP_XOR: begin
              acc_q <= alu_r;
              c_q   <= 1'b0;
              v_q   <= 1'b0;
            end
            OP_ADD, OP_SUB: begin
              acc_q <= alu_r;
              c_q   <= alu_c;
              v_q   <= alu_v;
            end
            OP_NOT: begin
              acc_q <= ~acc_q;
              c_q   <= 1'b0;
              v_q   <= 1'b0;
            end
            default: err_q <= 1'b1;
          endcase
        end
        MUL: begin
          p      <= p_nx;
          m      <= m << 1;
          sticky <= sticky_nx;
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state  <= IDLE;
            acc_q  <= p_nx;
            c_q    <= sticky_nx;
            v_q    <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: behavioural alu beside each instance,
// hand-computed accumulator/flag/latency expectations.
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_opnd;
  logic [7:0] alu_a, alu_b, alu_r;
  logic [3:0] alu_s;
  logic       alu_c, alu_v;
  logic [7:0] acc;
  logic       flag_c, flag_v, flag_z, busy, done, err;

  logic       n_cmd_valid, n_cmd_ready;
  logic [3:0] n_cmd_op;
  logic [7:0] n_cmd_opnd;
  logic [7:0] n_alu_a, n_alu_b, n_alu_r;
  logic [3:0] n_alu_s;
  logic       n_alu_c, n_alu_v;
  logic [7:0] n_acc;
  logic       n_flag_c, n_flag_v, n_flag_z, n_busy, n_done, n_err;

  int checks = 0;
  int errors = 0;

  alu_seq_ctrl #(.MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_opnd(cmd_opnd), .alu_a(alu_a), .alu_b(alu_b),
    .alu_s(alu_s), .alu_r(alu_r), .alu_c(alu_c), .alu_v(alu_v), .acc(acc),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .busy(busy),
    .done(done), .err(err)
  );

  alu_seq_ctrl #(.MUL_EN(0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .cmd_valid(n_cmd_valid), .cmd_ready(n_cmd_ready),
    .cmd_op(n_cmd_op), .cmd_opnd(n_cmd_opnd), .alu_a(n_alu_a), .alu_b(n_alu_b),
    .alu_s(n_alu_s), .alu_r(n_alu_r), .alu_c(n_alu_c), .alu_v(n_alu_v), .acc(n_acc),
    .flag_c(n_flag_c), .flag_v(n_flag_v), .flag_z(n_flag_z), .busy(n_busy),
    .done(n_done), .err(n_err)
  );

  function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] s);
    logic [8:0] t;
    logic [7:0] r;
    logic       c, v;
    t = '0; r = '0; c = 1'b0; v = 1'b0;
    case (s)
      4'b1000: r = a;
      4'b1110: r = a & b;
      4'b1101: r = a | b;
      4'b1011: r = a ^ b;
      4'b1100: r = ~a;
      4'b1010: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[7:0];
        c = t[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'b1001: begin
        t = {1'b0, a} - {1'b0, b};
        r = t[7:0];
        c = ~t[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      default: r = 8'hEE;
    endcase
    return {c, v, r};
  endfunction

  always_comb {alu_c, alu_v, alu_r} = alu_f(alu_a, alu_b, alu_s);
  always_comb {n_alu_c, n_alu_v, n_alu_r} = alu_f(n_alu_a, n_alu_b, n_alu_s);

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command at a negedge and follow it to its done pulse; poke
  // presents a competing command in the fourth busy cycle.
  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [7:0] opnd,
                         input int lat, input logic [7:0] eacc, input logic ec,
                         input logic ev, input logic eerr, input bit poke);
    int n;
    n = 0;
    check({tag, "/ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_opnd  = opnd;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    do begin
      @(negedge clk);
      n++;
      cmd_valid = 1'b0;
      if (!done) check({tag, "/busy"}, busy, 1);
      if (poke && n == 4) begin
        check({tag, "/ready_mid"}, cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_op    = 4'h0;
        cmd_opnd  = 8'h55;
      end
    end while (!done && n < 20);
    check({tag, "/lat"}, 16'(n), 16'(lat));
    check({tag, "/acc"}, acc, eacc);
    check({tag, "/c"}, flag_c, ec);
    check({tag, "/v"}, flag_v, ev);
    check({tag, "/z"}, flag_z, (eacc == 8'h00));
    check({tag, "/err"}, err, eerr);
    check({tag, "/busy_end"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_opnd = '0;
    n_cmd_valid = 1'b0; n_cmd_op = '0; n_cmd_opnd = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst/acc", acc, 8'h00);
    check("rst/z", flag_z, 1);
    check("rst/c", flag_c, 0);
    check("rst/v", flag_v, 0);
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/err", err, 0);
    check("rst/alu_s", alu_s, 4'b1000);
    check("rst/alu_a", alu_a, 8'h00);
    check("rst/alu_b", alu_b, 8'h00);
    check("rst/ready", cmd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL_EN=0 instance: op 7 takes the illegal path
    n_cmd_valid = 1'b1; n_cmd_op = 4'h0; n_cmd_opnd = 8'h09;
    @(posedge clk); #1 n_cmd_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("nomul/load_done", n_done, 1);
    check("nomul/load_acc", n_acc, 8'h09);
    n_cmd_valid = 1'b1; n_cmd_op = 4'h7; n_cmd_opnd = 8'h03;
    @(posedge clk); #1 n_cmd_valid = 1'b0;
    @(negedge clk);
    check("nomul/busy", n_busy, 1);
    check("nomul/early_done", n_done, 0);
    @(negedge clk);
    check("nomul/done", n_done, 1);
    check("nomul/err", n_err, 1);
    check("nomul/acc", n_acc, 8'h09);
    @(negedge clk);
    check("nomul/done_off", n_done, 0);

    run_cmd("load7f", 4'h0, 8'h7F, 2, 8'h7F, 0, 0, 0, 0);
    run_cmd("add01",  4'h4, 8'h01, 2, 8'h80, 0, 1, 0, 0);
    run_cmd("load80", 4'h0, 8'h80, 2, 8'h80, 0, 0, 0, 0);
    run_cmd("add80",  4'h4, 8'h80, 2, 8'h00, 1, 1, 0, 0);
    run_cmd("load05", 4'h0, 8'h05, 2, 8'h05, 0, 0, 0, 0);
    run_cmd("sub05",  4'h5, 8'h05, 2, 8'h00, 1, 0, 0, 0);
    run_cmd("load03", 4'h0, 8'h03, 2, 8'h03, 0, 0, 0, 0);
    run_cmd("sub05b", 4'h5, 8'h05, 2, 8'hFE, 0, 0, 0, 0);
    run_cmd("loadff", 4'h0, 8'hFF, 2, 8'hFF, 0, 0, 0, 0);
    run_cmd("addwrap",4'h4, 8'h01, 2, 8'h00, 1, 0, 0, 0);
    run_cmd("loadf0", 4'h0, 8'hF0, 2, 8'hF0, 0, 0, 0, 0);
    run_cmd("and3c",  4'h1, 8'h3C, 2, 8'h30, 0, 0, 0, 0);
    run_cmd("or0f",   4'h2, 8'h0F, 2, 8'h3F, 0, 0, 0, 0);
    run_cmd("xorff",  4'h3, 8'hFF, 2, 8'hC0, 0, 0, 0, 0);
    run_cmd("not",    4'h6, 8'h00, 2, 8'h3F, 0, 0, 0, 0);
    run_cmd("load0c", 4'h0, 8'h0C, 2, 8'h0C, 0, 0, 0, 0);
    run_cmd("mul0b",  4'h7, 8'h0B, 9, 8'h84, 0, 0, 0, 0);
    run_cmd("load0f", 4'h0, 8'h0F, 2, 8'h0F, 0, 0, 0, 0);
    run_cmd("mul11",  4'h7, 8'h11, 9, 8'hFF, 0, 0, 0, 0);
    run_cmd("load33", 4'h0, 8'h33, 2, 8'h33, 0, 0, 0, 0);
    run_cmd("mul00",  4'h7, 8'h00, 9, 8'h00, 0, 0, 0, 0);
    run_cmd("load20", 4'h0, 8'h20, 2, 8'h20, 0, 0, 0, 0);
    run_cmd("mul10",  4'h7, 8'h10, 9, 8'h00, 1, 0, 0, 1);
    run_cmd("load5b", 4'h0, 8'h5B, 2, 8'h5B, 0, 0, 0, 0);
    run_cmd("sub01",  4'h5, 8'h01, 2, 8'h5A, 1, 0, 0, 0);
    run_cmd("illF",   4'hF, 8'h00, 2, 8'h5A, 1, 0, 1, 0);

    // reset in the middle of a multiply
    run_cmd("load03r", 4'h0, 8'h03, 2, 8'h03, 0, 0, 0, 0);
    cmd_valid = 1'b1; cmd_op = 4'h7; cmd_opnd = 8'h07;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rstmul/busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstmul/acc", acc, 8'h00);
    check("rstmul/z", flag_z, 1);
    check("rstmul/busy", busy, 0);
    check("rstmul/done", done, 0);
    check("rstmul/ready", cmd_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmul/no_done", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd("load11", 4'h0, 8'h11, 2, 8'h11, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
